// File: rtl/canny_hyst_stream.sv
// Streaming Canny hysteresis: classifies NMS magnitudes and emits 0xFF/0x00 edge pixels from a 3x3 class window.
// Optional macro CANNY_HYST_STATS_EN adds per-frame strong_cnt / promoted_cnt outputs.
module canny_hyst_stream #(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480,
   parameter int unsigned MAG_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [MAG_W-1:0] t_low,
   input  logic [MAG_W-1:0] t_high,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sof,
   input  logic [MAG_W-1:0] in_mag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sof,
   output logic [7:0]       out_edge,
   output logic             err_sof
`ifdef CANNY_HYST_STATS_EN
   ,
   output logic [31:0]      strong_cnt,
   output logic [31:0]      promoted_cnt
`endif
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H + 2);

   localparam logic [1:0] C_NONE   = 2'd0;
   localparam logic [1:0] C_WEAK   = 2'd1;
   localparam logic [1:0] C_STRONG = 2'd2;

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
   // Window column: [0] row above centre, [1] centre row, [2] row below.
   typedef logic [2:0][1:0] col_t;

   state_t state, state_nx;

   logic [RW-1:0]    row;
   logic [CW-1:0]    col;
   logic             flush_done;
   logic [MAG_W-1:0] lat_lo, lat_hi;
   col_t             win_a, win_b;
   logic [1:0]       lb0 [IMG_W];
   logic [1:0]       lb1 [IMG_W];

   logic             accept, start, restart, step_real, step_virt, step, out_free;
   logic             emit, emit_sof, pix_edge, strong_nb, last_in, last_virt, final_acc;
   logic [RW-1:0]    pos_row;
   logic [CW-1:0]    pos_col;
   logic [MAG_W-1:0] lo_eff, hi_eff;
   logic [1:0]       cls_in;
   col_t             cur_col, left_col, right_col;

   // Handshake and step qualification; FLUSH feeds virtual NONE pixels to drain the window.
   always_comb begin
      out_free  = !out_valid || out_ready;
      in_ready  = rst_n && ((state == IDLE) || (state == FILL) || ((state == RUN) && out_free));
      accept    = in_valid && in_ready;
      start     = accept && in_sof;
      restart   = start && (state != IDLE);
      step_real = accept && !in_sof && ((state == FILL) || (state == RUN));
      step_virt = (state == FLUSH) && !flush_done && out_free;
      step      = start || step_real || step_virt;
      pos_row   = start ? '0 : row;
      pos_col   = start ? '0 : col;
      last_in   = (pos_row == RW'(IMG_H - 1)) && (pos_col == CW'(IMG_W - 1));
      last_virt = (pos_row == RW'(IMG_H + 1)) && (pos_col == '0);
      final_acc = (state == FLUSH) && flush_done && out_valid && out_ready;
   end

   // Classification; the sof pixel sees live thresholds, the rest of the frame the latched ones.
   always_comb begin
      hi_eff = in_sof ? t_high : lat_hi;
      lo_eff = in_sof ? t_low : lat_lo;
      if (lo_eff > hi_eff) lo_eff = hi_eff;
      cls_in = C_NONE;
      if (in_mag >= hi_eff)      cls_in = C_STRONG;
      else if (in_mag >= lo_eff) cls_in = C_WEAK;
   end

   // Column assembly with out-of-frame rows/columns forced to NONE.
   always_comb begin
      cur_col    = '0;
      cur_col[0] = (pos_row >= RW'(2)) ? lb1[pos_col] : C_NONE;
      cur_col[1] = (pos_row >= RW'(1)) ? lb0[pos_col] : C_NONE;
      cur_col[2] = (pos_row < RW'(IMG_H)) ? cls_in : C_NONE;
      left_col   = (pos_col == CW'(1)) ? col_t'('0) : win_a;
      right_col  = (pos_col == '0) ? col_t'('0) : cur_col;
      strong_nb  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if ((left_col[i] == C_STRONG) || (right_col[i] == C_STRONG)) strong_nb = 1'b1;
      end
      if ((win_b[0] == C_STRONG) || (win_b[2] == C_STRONG)) strong_nb = 1'b1;
      pix_edge = (win_b[1] == C_STRONG) || ((win_b[1] == C_WEAK) && strong_nb);
      emit     = step && ((pos_row >= RW'(2)) || ((pos_row == RW'(1)) && (pos_col != '0)));
      emit_sof = (pos_row == RW'(1)) && (pos_col == CW'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = FILL;
         FILL:  if (restart) state_nx = FILL;
                else if (step_real && emit_sof) state_nx = RUN;
         RUN:   if (restart) state_nx = FILL;
                else if (step_real && last_in) state_nx = FLUSH;
         FLUSH: if (final_acc) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Raster position, threshold latch, window shift and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row        <= '0;
         col        <= '0;
         flush_done <= 1'b0;
         lat_lo     <= '0;
         lat_hi     <= '0;
         win_a      <= '0;
         win_b      <= '0;
         out_valid  <= 1'b0;
         out_sof    <= 1'b0;
         out_edge   <= 8'h00;
         err_sof    <= 1'b0;
      end else begin
         err_sof <= restart;
         if (start) begin
            lat_lo     <= t_low;
            lat_hi     <= t_high;
            flush_done <= 1'b0;
         end
         if (step) begin
            if (pos_col == CW'(IMG_W - 1)) begin
               col <= '0;
               row <= pos_row + RW'(1);
            end else begin
               col <= pos_col + CW'(1);
               row <= pos_row;
            end
            win_a <= win_b;
            win_b <= cur_col;
            if (step_virt && last_virt) flush_done <= 1'b1;
         end
         if (restart) begin
            out_valid <= 1'b0;
         end else if (emit) begin
            out_valid <= 1'b1;
            out_sof   <= emit_sof;
            out_edge  <= pix_edge ? 8'hFF : 8'h00;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Line buffers: lb0 holds the previous line, lb1 the one before; contents need no reset.
   always_ff @(posedge clk) begin
      if (step && (pos_row < RW'(IMG_H))) begin
         lb1[pos_col] <= lb0[pos_col];
         lb0[pos_col] <= cls_in;
      end
   end

`ifdef CANNY_HYST_STATS_EN
   logic [31:0] acc_strong, acc_prom;
   logic        stats_upd;

   // Per-frame accumulation, published one cycle after the final output is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_strong   <= '0;
         acc_prom     <= '0;
         stats_upd    <= 1'b0;
         strong_cnt   <= '0;
         promoted_cnt <= '0;
      end else begin
         stats_upd <= final_acc;
         if (start) begin
            acc_strong <= '0;
            acc_prom   <= '0;
         end else if (emit) begin
            if (win_b[1] == C_STRONG)            acc_strong <= acc_strong + 32'd1;
            if ((win_b[1] == C_WEAK) && pix_edge) acc_prom   <= acc_prom + 32'd1;
         end
         if (stats_upd) begin
            strong_cnt   <= acc_strong;
            promoted_cnt <= acc_prom;
         end
      end
   end
`endif

endmodule

// File: tb/tb_canny_hyst_stream.sv
// Scoreboard bench for canny_hyst_stream on a 4x4 frame: a reference model queues expected pixels, a monitor pops them.
module tb_canny_hyst_stream;
   localparam int W = 4;
   localparam int H = 4;
   localparam int N = W * H;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] t_low, t_high, in_mag;
   logic        in_valid, in_ready, in_sof;
   logic        out_valid, out_sof, err_sof;
   logic        out_ready = 1'b1;
   logic [7:0]  out_edge;

   int          ncmp = 0;
   int          nfail = 0;
   int          err_cnt = 0;
   int          out_cnt = 0;
   int          cyc = 0;
   bit          tog = 1'b0;
   bit          hold_chk = 1'b0;
   logic [8:0]  held;
   logic [8:0]  mon_e;
   int          img [N];
   logic [8:0]  exp_q [$];
   int          snap;

   canny_hyst_stream #(.IMG_W(W), .IMG_H(H), .MAG_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .t_low(t_low), .t_high(t_high),
      .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_mag(in_mag),
      .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
      .out_edge(out_edge), .err_sof(err_sof)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Downstream backpressure: either always ready or ready one cycle in three.
   always @(negedge clk) begin
      cyc++;
      out_ready = tog ? ((cyc % 3) == 0) : 1'b1;
   end

   // Monitor: hold-stability check, scoreboard pop on each handshake, err_sof pulse counting.
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         if (hold_chk) begin
            ncmp++;
            assert ({out_valid, out_sof, out_edge} === {1'b1, held})
            else begin nfail++; $error("FAIL hold obs=%h exp=%h", {out_valid, out_sof, out_edge}, {1'b1, held}); end
         end
         if (out_valid && out_ready) begin
            out_cnt++;
            ncmp++;
            if (exp_q.size() == 0) begin
               assert (1'b0 === 1'b1)
               else begin nfail++; $error("FAIL unexpected_out obs=%h exp=none", {out_sof, out_edge}); end
            end else begin
               mon_e = exp_q.pop_front();
               assert ({out_sof, out_edge} === mon_e)
               else begin nfail++; $error("FAIL pixel obs=%h exp=%h", {out_sof, out_edge}, mon_e); end
            end
         end
         hold_chk = out_valid && !out_ready;
         held     = {out_sof, out_edge};
         if (err_sof) err_cnt++;
      end else begin
         hold_chk = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp)
      else begin nfail++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp); end
   endtask

   // Reference model: classify, then hysteresis with in-bounds 8-neighbours only.
   task automatic push_model(input int lo, input int hi, input int n);
      int cl [N];
      int lo_e;
      bit e;
      lo_e = (lo > hi) ? hi : lo;
      for (int i = 0; i < N; i++)
         cl[i] = (img[i] >= hi) ? 2 : ((img[i] >= lo_e) ? 1 : 0);
      for (int q = 0; q < n; q++) begin
         int r, c;
         r = q / W;
         c = q % W;
         e = (cl[q] == 2);
         if (cl[q] == 1) begin
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < H &&
                      (c + dc) >= 0 && (c + dc) < W && cl[(r + dr) * W + c + dc] == 2)
                     e = 1'b1;
         end
         exp_q.push_back({(q == 0), (e ? 8'hFF : 8'h00)});
      end
   endtask

   task automatic drive_px(input int m, input bit s);
      int g;
      @(negedge clk);
      in_valid = 1'b1;
      in_mag   = 16'(m);
      in_sof   = s;
      #1;
      g = 0;
      while (!in_ready && g < 200) begin
         @(negedge clk);
         #1;
         g++;
      end
      if (g >= 200) chk("in_ready_timeout", 32'(g), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Drives npx pixels of img; thresholds switch to lo2/hi2 right after the sof pixel.
   task automatic send_frame(input int lo, input int hi, input int lo2, input int hi2, input int npx);
      t_low  = 16'(lo);
      t_high = 16'(hi);
      for (int i = 0; i < npx; i++) begin
         drive_px(img[i], i == 0);
         if (i == 0) begin
            t_low  = 16'(lo2);
            t_high = 16'(hi2);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int g;
      g = 0;
      while ((exp_q.size() != 0 || out_valid) && g < 600) begin
         @(negedge clk);
         g++;
      end
      #3;
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic fill_img(input int v);
      for (int i = 0; i < N; i++) img[i] = v;
   endtask

   initial begin
      in_valid = 1'b0; in_sof = 1'b0; in_mag = '0;
      t_low = 16'd50; t_high = 16'd100;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sof",   32'(out_sof),   32'd0);
      chk("rst_out_edge",  32'(out_edge),  32'd0);
      chk("rst_err_sof",   32'(err_sof),   32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // All strong: every output 0xFF, sof on first only.
      fill_img(120);
      snap = out_cnt;
      push_model(50, 100, N);
      send_frame(50, 100, 50, 100, N);
      wait_drain("drain_all_strong");
      chk("cnt_all_strong", 32'(out_cnt - snap), 32'(N));
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      // Weak centre promoted by a corner strong neighbour.
      fill_img(0); img[5] = 70; img[0] = 150;
      push_model(50, 100, N);
      send_frame(50, 100, 50, 100, N);
      wait_drain("drain_promote");

      // Weak (1,1) with strong only at (3,3): no promotion, no wrap.
      fill_img(0); img[5] = 70; img[15] = 150;
      push_model(50, 100, N);
      send_frame(50, 100, 50, 100, N);
      wait_drain("drain_no_wrap");

      // Thresholds latched at sof; port changes mid-frame are ignored.
      img = '{120, 0, 70, 0, 0, 70, 0, 0, 30, 0, 0, 60, 0, 80, 0, 200};
      push_model(50, 100, N);
      send_frame(50, 100, 0, 10, N);
      wait_drain("drain_latch");

      // Backpressure: ready one cycle in three.
      for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 160);
      tog = 1'b1;
      snap = out_cnt;
      push_model(50, 100, N);
      send_frame(50, 100, 50, 100, N);
      wait_drain("drain_backpressure");
      chk("cnt_backpressure", 32'(out_cnt - snap), 32'(N));
      tog = 1'b0;
      repeat (2) @(negedge clk);

      // sof reasserted at pixel 7: err_sof pulse, new frame complete.
      err_cnt = 0;
      for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 160);
      push_model(50, 100, 2);
      send_frame(50, 100, 50, 100, 7);
      img = '{0, 60, 0, 0, 0, 0, 130, 0, 55, 0, 0, 0, 0, 0, 75, 160};
      push_model(50, 100, N);
      send_frame(50, 100, 50, 100, N);
      wait_drain("drain_restart");
      chk("err_sof_pulses", 32'(err_cnt), 32'd1);

      // Inverted thresholds: 150 strong, 80 none even beside strong.
      fill_img(0); img[0] = 150; img[1] = 80; img[10] = 80;
      push_model(200, 100, N);
      send_frame(200, 100, 200, 100, N);
      wait_drain("drain_inverted");

      // Non-sof pixels in IDLE are dropped.
      snap = out_cnt;
      for (int i = 0; i < 3; i++) drive_px(150, 1'b0);
      @(negedge clk); in_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("idle_drop", 32'(out_cnt - snap), 32'd0);

      // Reset mid-frame: three outputs already out, nothing after.
      fill_img(120);
      push_model(50, 100, 3);
      send_frame(50, 100, 50, 100, 8);
      repeat (2) @(negedge clk);
      snap = out_cnt;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready",  32'(in_ready),  32'd0);
      chk("midrst_err_sof",   32'(err_sof),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("midrst_no_out", 32'(out_cnt - snap), 32'd0);
      chk("midrst_queue", 32'(exp_q.size()), 32'd0);

      // Recovery after reset.
      img = '{0, 0, 0, 0, 0, 70, 150, 0, 0, 60, 0, 0, 0, 0, 0, 0};
      push_model(50, 100, N);
      send_frame(50, 100, 50, 100, N);
      wait_drain("drain_recover");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
